// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory fetch bus between the fetch stage (master) and imem (slave).
interface if_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] imem_pc;
    logic [DATA_WIDTH-1:0] imem_instr;
    modport master (output imem_pc, input imem_instr);
    modport slave (input imem_pc, output imem_instr);
endinterface

// File: rtl/if_stage.sv
// if_stage: RV fetch stage with PC register and IF/ID pipeline register.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky FAULT state.
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    if_stage_if.master            imem,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_pc4,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid,
    output logic [31:0]           fetch_count,
    output logic                  fetch_fault
);
    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_plus4;
    assign pc_plus4      = pc_q + DATA_WIDTH'(4);
    assign imem.imem_pc  = pc_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign fetch_fault   = (state == FAULT);
`else
    assign fetch_fault   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                RUN: begin
                    if (redirect) begin
                        // redirect wins over stall: the fetched word is on the wrong path
                        if_id_instr <= NOP_INSTR;
                        if_id_valid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
                        if (|redirect_pc[1:0]) state <= FAULT;
                        else pc_q <= redirect_pc;
`else
                        pc_q <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
`endif
                    end else if (!stall) begin
                        if_id_instr <= imem.imem_instr;
                        if_id_pc    <= pc_q;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                        pc_q        <= pc_plus4;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                FAULT: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC and instruction paths.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble encoding.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hazard-unit hold request (load-use).
REQ-007 SHALL have port redirect  input  1  taken branch/jump from EX.
REQ-008 SHALL have port redirect_pc  input  DATA_WIDTH  redirect target byte address.
REQ-009 SHALL have port imem_pc  output  DATA_WIDTH  fetch address to instruction memory.
REQ-010 SHALL have port imem_instr  input  DATA_WIDTH  combinational instruction word returned for imem_pc.
REQ-011 SHALL have port if_id_pc  output  DATA_WIDTH  PC of the instruction held in IF/ID.
REQ-012 SHALL have port if_id_pc4  output  DATA_WIDTH  if_id_pc + 4.
REQ-013 SHALL have port if_id_instr  output  DATA_WIDTH  instruction held in IF/ID.
REQ-014 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-015 SHALL have port fetch_count  output  32  count of instructions loaded into IF/ID.
REQ-016 SHALL have port fetch_fault  output  1  sticky misaligned-redirect flag.

Function
REQ-017 SHALL drive imem_pc combinationally from internal register pc_q.
REQ-018 SHALL implement FSM BOOT, RUN, FAULT; rst forces BOOT.
REQ-019 SHALL, in BOOT, hold pc_q, keep IF/ID a bubble, ignore stall/redirect, and go to RUN next cycle unconditionally.
REQ-020 SHALL, in RUN, apply priority redirect > stall > advance each cycle.
REQ-021 SHALL, on redirect, load pc_q <= redirect_pc and flush IF/ID (valid 0, instr NOP_INSTR) on the same edge, even when stall=1.
REQ-022 SHALL, on stall without redirect, hold pc_q, all IF/ID fields and fetch_count.
REQ-023 SHALL, on advance, load if_id_instr <= imem_instr, if_id_pc <= pc_q, if_id_pc4 <= pc_q+4, if_id_valid <= 1, pc_q <= pc_q+4, fetch_count += 1.
REQ-024 SHALL compute pc_q+4 modulo 2^DATA_WIDTH (32'hFFFF_FFFC advances to 32'h0000_0000).
REQ-025 SHALL let fetch_count wrap from 32'hFFFF_FFFF to 0.
REQ-026 SHALL, in FAULT, hold pc_q, fetch_count and fetch_fault=1, force IF/ID to bubble, and leave FAULT only via rst.
REQ-027 SHALL keep latency fetch-to-IF/ID at exactly one cycle.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, set pc_q=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_count=0, fetch_fault=0, state=BOOT.
REQ-029 SHALL give rst priority over stall, redirect and FAULT in any state, mid-operation included.

Configuration
REQ-030 SHALL, with macro IF_MISALIGN_TRAP_EN defined, enter FAULT when redirect=1 and redirect_pc[1:0]!=0 in RUN, with pc_q and IF/ID flushed, not loaded.
REQ-031 SHALL, without IF_MISALIGN_TRAP_EN, load pc_q <= {redirect_pc[DATA_WIDTH-1:2],2'b00}, tie fetch_fault to 0, and make FAULT unreachable.

Verification
REQ-032 SHALL cover reset release, no stall/redirect: imem_pc 0,0,4,8,...; if_id_valid first 1 two edges after rst low with if_id_pc=0; fetch_count=3 after 3 advances.
REQ-033 SHALL cover stall=1 for 2 cycles at imem_pc=0x10: imem_pc, if_id_pc=0x0C, fetch_count frozen, resumes at 0x14.
REQ-034 SHALL cover redirect=1, redirect_pc=0x40, with stall=1 simultaneously: next imem_pc=0x40, if_id_valid=0, if_id_instr=0x00000013.
REQ-035 SHALL cover RESET_PC=32'hFFFF_FFFC: after advance imem_pc=0, if_id_pc=0xFFFF_FFFC, if_id_pc4=0.
REQ-036 SHALL cover redirect_pc=0x42: with IF_MISALIGN_TRAP_EN fetch_fault=1 and imem_pc held; without it imem_pc=0x40, fetch_fault=0.
REQ-037 SHALL cover rst=1 asserted during stall in FAULT: next edge all outputs equal REQ-028 values.
